// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the keyboard scan sequencer.
// No logic of its own; latency and backpressure are defined by the users.
// The key_t layout {ext, code} matches the held_code output bit order.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2,
    DECODE = 2'd3
  } state_t;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_ERR0 = 8'h00;
  localparam logic [7:0] SC_ERR1 = 8'hFF;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_t;

  // Receiver error bytes: they carry no key and abort any prefix.
  function automatic logic is_err_code(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/kbd_prefix_timer.sv
// Watchdog for a pending E0/F0 prefix waiting on its code byte.
// expire asserts combinationally on the TIMEOUT_CYCLES-th consecutive start cycle.
// No backpressure: start/clear are sampled every clock, clear has priority.
module kbd_prefix_timer #(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expire
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  assign expire = start && (cnt == LAST);

  // Count run cycles; restart on a pop or once the limit has fired.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || expire) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/kbd_scan_sequencer.sv
// Drains the PS/2 receiver FIFO and turns set-2 scan bytes into key events.
// Latency: 4 clk from fifo_ready in IDLE to evt_valid; 4 clk per byte thereafter.
// Backpressure: none downstream; pops only when fifo_ready, at most one per 4 clk.
module kbd_scan_sequencer
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_ready,
  input  logic             fifo_overflow,
  output logic             nextdata_n,
  input  logic             clr_err,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             held,
  output logic [8:0]       held_code,
  output logic [CNT_W-1:0] press_count,
  output logic             ovf_err
);

  state_t     state;
  logic [7:0] byte_r;
  logic       ext_pend;
  logic       brk_pend;
  logic       ovf_pend;

  logic       pop;
  logic       tmr_run;
  logic       tmr_expire;
  logic       ovf_now;
  logic       dec_ext;
  logic       dec_brk;
  key_t       key_c;
  logic       key_match;

  // A byte is taken only from IDLE so pops are spaced by the full 4-state loop.
  assign pop     = (state == IDLE) && fifo_ready;
  assign tmr_run = (ext_pend || brk_pend) && (state == IDLE) && !fifo_ready;

  // An overflow anywhere since the last decode invalidates the pending prefixes,
  // including one arriving in the decode cycle itself.
  assign ovf_now   = ovf_pend || fifo_overflow;
  assign dec_ext   = ext_pend && !ovf_now;
  assign dec_brk   = brk_pend && !ovf_now;
  assign key_c     = {dec_ext, byte_r};
  assign key_match = held && (held_code == key_c);

  kbd_prefix_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_prefix_timer (
    .clk   (clk),
    .rst   (rst),
    .start (tmr_run),
    .clear (pop),
    .expire(tmr_expire)
  );

  // Pop/settle/decode sequencer with registered handshake and event outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      byte_r      <= '0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      ovf_pend    <= 1'b0;
      nextdata_n  <= 1'b1;
      evt_valid   <= 1'b0;
      evt_code    <= '0;
      evt_ext     <= 1'b0;
      evt_break   <= 1'b0;
      held        <= 1'b0;
      held_code   <= '0;
      press_count <= '0;
      ovf_err     <= 1'b0;
    end else begin
      evt_valid  <= 1'b0;
      nextdata_n <= 1'b1;
      ovf_pend   <= ovf_now;

      // Set beats clear when both arrive together.
      if (fifo_overflow) begin
        ovf_err <= 1'b1;
      end else if (clr_err) begin
        ovf_err <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (fifo_ready) begin
            byte_r     <= fifo_data;
            nextdata_n <= 1'b0;
            state      <= POP;
          end else if (tmr_expire) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
        end
        POP: begin
          state <= SETTLE;
        end
        SETTLE: begin
          state <= DECODE;
        end
        DECODE: begin
          state    <= IDLE;
          ovf_pend <= 1'b0;
          ext_pend <= dec_ext;
          brk_pend <= dec_brk;
          if (byte_r == SC_EXT) begin
            ext_pend <= 1'b1;
          end else if (byte_r == SC_BRK) begin
            brk_pend <= 1'b1;
          end else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            if (!is_err_code(byte_r)) begin
              evt_valid <= 1'b1;
              evt_code  <= byte_r;
              evt_ext   <= dec_ext;
              evt_break <= dec_brk;
              if (!dec_brk) begin
                // A make of the already-held key is typematic and not counted.
                if (!key_match) begin
                  press_count <= press_count + CNT_W'(1);
                  held        <= 1'b1;
                  held_code   <= key_c;
                end
              end else if (key_match) begin
                held      <= 1'b0;
                held_code <= '0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_scan_sequencer.sv
// Bench for kbd_scan_sequencer: directed scenarios plus randomized byte streams.
// A byte-level reference model predicts every output each cycle.
// The receiver FIFO is modelled as a queue popped on the nextdata_n strobe.
module tb_kbd_scan_sequencer;

  localparam int TMO = 16;

  logic       clk;
  logic       rst;
  logic [7:0] fifo_data;
  logic       fifo_ready;
  logic       fifo_overflow;
  logic       nextdata_n;
  logic       clr_err;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       held;
  logic [8:0] held_code;
  logic [7:0] press_count;
  logic       ovf_err;

  kbd_scan_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_data    (fifo_data),
    .fifo_ready   (fifo_ready),
    .fifo_overflow(fifo_overflow),
    .nextdata_n   (nextdata_n),
    .clr_err      (clr_err),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_ext      (evt_ext),
    .evt_break    (evt_break),
    .held         (held),
    .held_code    (held_code),
    .press_count  (press_count),
    .ovf_err      (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int nd_low_cnt = 0;
  int ev_cnt = 0;

  logic [7:0] q[$];
  logic       nd_seen = 1'b1;

  // Reference model state
  int         m_left = 0;
  int         m_tcnt = 0;
  logic [7:0] m_byte = '0;
  logic       m_pext = 0, m_pbrk = 0, m_ovfp = 0;
  logic       m_nd = 1, m_vld = 0, m_eext = 0, m_ebrk = 0, m_held = 0, m_ovf = 0;
  logic [7:0] m_code = '0, m_pc = '0;
  logic [8:0] m_hcode = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    fifo_ready = (q.size() != 0);
    fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    drive();
  endtask

  task automatic model_decode(input logic ovf);
    logic [8:0] key;
    if (ovf) begin
      m_pext = 0;
      m_pbrk = 0;
    end
    if (m_byte == 8'hE0) m_pext = 1;
    else if (m_byte == 8'hF0) m_pbrk = 1;
    else begin
      if (m_byte != 8'h00 && m_byte != 8'hFF) begin
        key    = {m_pext, m_byte};
        m_vld  = 1;
        m_code = m_byte;
        m_eext = m_pext;
        m_ebrk = m_pbrk;
        if (!m_pbrk) begin
          if (!(m_held && m_hcode == key)) begin
            m_pc    = m_pc + 8'd1;
            m_held  = 1;
            m_hcode = key;
          end
        end else if (m_held && m_hcode == key) begin
          m_held  = 0;
          m_hcode = '0;
        end
      end
      m_pext = 0;
      m_pbrk = 0;
    end
  endtask

  // Advance the model by one clock using the inputs the DUT samples at this edge.
  task automatic model_step();
    m_vld = 0;
    m_nd  = 1;
    if (!rst) begin
      m_left = 0; m_tcnt = 0; m_byte = '0;
      m_pext = 0; m_pbrk = 0; m_ovfp = 0;
      m_code = '0; m_eext = 0; m_ebrk = 0;
      m_held = 0; m_hcode = '0; m_pc = '0; m_ovf = 0;
    end else begin
      if (fifo_overflow) m_ovf = 1;
      else if (clr_err) m_ovf = 0;
      if (m_left == 0) begin
        m_ovfp = m_ovfp | fifo_overflow;
        if (fifo_ready) begin
          m_byte = fifo_data;
          m_left = 3;
          m_nd   = 0;
          m_tcnt = 0;
        end else if (m_pext || m_pbrk) begin
          m_tcnt++;
          if (m_tcnt == TMO) begin
            m_pext = 0;
            m_pbrk = 0;
            m_tcnt = 0;
          end
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          model_decode(m_ovfp | fifo_overflow);
          m_ovfp = 0;
        end else begin
          m_ovfp = m_ovfp | fifo_overflow;
        end
      end
    end
  endtask

  task automatic compare();
    check("nextdata_n",  32'(nextdata_n),  32'(m_nd));
    check("evt_valid",   32'(evt_valid),   32'(m_vld));
    check("evt_fields",  32'({evt_code, evt_ext, evt_break}), 32'({m_code, m_eext, m_ebrk}));
    check("held",        32'({held, held_code}), 32'({m_held, m_hcode}));
    check("press_count", 32'(press_count), 32'(m_pc));
    check("ovf_err",     32'(ovf_err),     32'(m_ovf));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    if (!nd_seen && q.size() != 0) q.delete(0);
    @(negedge clk);
    fifo_overflow = 1'b0;
    clr_err       = 1'b0;
    compare();
    nd_seen = nextdata_n;
    if (!nextdata_n) nd_low_cnt++;
    if (evt_valid) ev_cnt++;
    drive();
  endtask

  task automatic wait_evt(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!evt_valid && n < 200);
    n_vec++;
    if (!evt_valid) begin
      n_bad++;
      $display("FAIL evt_wait: no evt_valid within %0d cycles, required one", n);
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((q.size() != 0 || m_left != 0) && n < bound) begin
      cycle();
      n++;
    end
    cycle();
    cycle();
    n_vec++;
    if (q.size() != 0 || m_left != 0) begin
      n_bad++;
      $display("FAIL drain: %0d bytes left after %0d cycles, required 0", q.size(), bound);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] pool [8];
    pool = '{8'h1C, 8'h32, 8'h75, 8'h1C, 8'hE0, 8'hF0, 8'h00, 8'hFF};
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(1, 254));
    return pool[$urandom_range(0, 7)];
  endfunction

  initial begin
    int n;
    logic [7:0] c;
    rst = 1'b0;
    fifo_overflow = 1'b0;
    clr_err = 1'b0;
    drive();

    // Reset state and single make code latency
    do_reset();
    check("rst_nextdata_n", 32'(nextdata_n), 32'd1);
    check("rst_press_count", 32'(press_count), 32'd0);
    check("rst_held_code", 32'(held_code), 32'd0);
    push(8'h1C);
    wait_evt(n);
    check("make_latency", 32'(n), 32'd4);
    check("make_code", 32'({evt_code, evt_ext, evt_break}), 32'({8'h1C, 1'b0, 1'b0}));
    check("make_count", 32'(press_count), 32'd1);
    check("make_held_code", 32'(held_code), 32'h01C);
    drain(50);

    // Typematic repeats followed by a break
    do_reset();
    nd_low_cnt = 0;
    ev_cnt = 0;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain(100);
    check("typematic_pops", 32'(nd_low_cnt), 32'd5);
    check("typematic_events", 32'(ev_cnt), 32'd4);
    check("typematic_count", 32'(press_count), 32'd1);
    check("typematic_held", 32'(held), 32'd0);

    // Extended make and extended break
    do_reset();
    push(8'hE0); push(8'h75);
    wait_evt(n);
    check("ext_make", 32'({evt_code, evt_ext, evt_break}), 32'({8'h75, 1'b1, 1'b0}));
    check("ext_held_code", 32'(held_code), 32'h175);
    push(8'hE0); push(8'hF0); push(8'h75);
    wait_evt(n);
    check("ext_break", 32'({evt_code, evt_ext, evt_break}), 32'({8'h75, 1'b1, 1'b1}));
    check("ext_break_held", 32'(held), 32'd0);
    check("ext_count", 32'(press_count), 32'd1);
    drain(50);

    // Prefix timeout, then a prefix that arrives just in time
    do_reset();
    push(8'hE0);
    repeat (40) cycle();
    push(8'h1C);
    wait_evt(n);
    check("timeout_ext", 32'(evt_ext), 32'd0);
    check("timeout_count", 32'(press_count), 32'd1);
    push(8'hE0);
    repeat (8) cycle();
    push(8'h75);
    wait_evt(n);
    check("in_time_ext", 32'(evt_ext), 32'd1);
    check("in_time_count", 32'(press_count), 32'd2);
    drain(50);

    // press_count wrap after 256 distinct presses
    do_reset();
    ev_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      c = (i % 2 == 0) ? 8'h1C : 8'h32;
      push(c); push(8'hF0); push(c);
    end
    drain(4000);
    check("wrap_count", 32'(press_count), 32'd0);
    check("wrap_events", 32'(ev_cnt), 32'd512);

    // Overflow drops the pending prefix; set beats clear
    do_reset();
    push(8'hE0);
    repeat (8) cycle();
    fifo_overflow = 1'b1;
    cycle();
    check("ovf_set", 32'(ovf_err), 32'd1);
    push(8'h75);
    wait_evt(n);
    check("ovf_prefix_dropped", 32'(evt_ext), 32'd0);
    fifo_overflow = 1'b1;
    clr_err = 1'b1;
    cycle();
    check("ovf_set_wins", 32'(ovf_err), 32'd1);
    clr_err = 1'b1;
    cycle();
    check("ovf_clear", 32'(ovf_err), 32'd0);

    // Reset while nextdata_n is low
    fifo_overflow = 1'b1;
    push(8'h1C);
    cycle();
    check("pop_low", 32'(nextdata_n), 32'd0);
    rst = 1'b0;
    cycle();
    check("midpop_rst", 32'({nextdata_n, evt_valid, evt_code, evt_ext, evt_break, held, held_code, press_count, ovf_err}),
          32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0}));
    rst = 1'b1;
    cycle();

    // Randomized byte streams, gaps, overflow/clear pulses and occasional reset
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 50) push(pick_byte());
      else if (r < 60) begin push(8'hE0); push(pick_byte()); end
      else if (r < 70) begin push(8'hF0); push(pick_byte()); end
      if ($urandom_range(0, 29) == 0) fifo_overflow = 1'b1;
      if ($urandom_range(0, 19) == 0) clr_err = 1'b1;
      rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      repeat ($urandom_range(1, ($urandom_range(0, 9) == 0) ? 30 : 6)) cycle();
    end
    rst = 1'b1;
    drain(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/kbd_scan_sequencer.md
Name: kbd_scan_sequencer

Overview:
Drains the PS/2 receiver FIFO using its ready/nextdata_n handshake and parses raw scan-code bytes into key events. Handles the set-2 prefixes E0 (extended) and F0 (break) and suppresses typematic repeats. Maintains the held key and a press counter. Sits between the ps2_keyboard receiver and the display/consumer logic, and replaces ad-hoc byte shifting in consumers.

Parameters:
TIMEOUT_CYCLES, 2500000, clk cycles a pending prefix may wait for its code byte before it is discarded (50 ms at 50 MHz)
CNT_W, 8, width of press_count

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
fifo_data  in  8  receiver FIFO head byte
fifo_ready  in  1  receiver FIFO non-empty
fifo_overflow  in  1  receiver FIFO overflow flag
nextdata_n  out  1  pop strobe to receiver, active-low, one-cycle pulse
clr_err  in  1  clears ovf_err
evt_valid  out  1  one-cycle pulse: new key event
evt_code  out  8  event scan code, held until next event
evt_ext  out  1  event had E0 prefix
evt_break  out  1  1 = release, 0 = press
held  out  1  a key is currently down
held_code  out  9  {ext, code} of held key
press_count  out  CNT_W  count of distinct presses, wraps
ovf_err  out  1  sticky: overflow seen

Behaviour:
- Reset (rst==0 at posedge): state IDLE; nextdata_n=1; evt_valid=0; evt_code=0; evt_ext=0; evt_break=0; held=0; held_code=0; press_count=0; ovf_err=0; ext_pend=0; brk_pend=0; timeout counter=0. Reset mid-sequence discards any latched byte and pending prefixes.
- FSM states: IDLE, POP, SETTLE, DECODE.
  - IDLE: if fifo_ready, latch fifo_data into byte_r, drive nextdata_n=0 for the next cycle, and go to POP.
  - POP: nextdata_n=0 (the only cycle it is low); go to SETTLE.
  - SETTLE: nextdata_n=1; one cycle for the receiver's read pointer and ready flag to update; go to DECODE.
  - DECODE: classify byte_r, then go to IDLE.
- Pop cadence: at most one pop every 4 cycles. nextdata_n is never low on two consecutive cycles. No pop occurs while fifo_ready==0.
- Decode rules:
  - byte 0xE0: set ext_pend.
  - byte 0xF0: set brk_pend.
  - byte 0x00 or 0xFF (error codes): clear both prefixes; no event.
  - Any other byte: emit an event, then clear both prefixes.
- Event emission: evt_code=byte_r, evt_ext=ext_pend, evt_break=brk_pend. evt_valid pulses high on the cycle after DECODE, with registered fields.
- Make event (brk_pend==0):
  - If held==1 and held_code=={ext_pend,byte_r}: typematic repeat. Event is still emitted; press_count unchanged.
  - Otherwise: press_count += 1 (modulo 2^CNT_W, so 255 -> 0 for CNT_W=8), held=1, held_code={ext_pend,byte_r}.
- Break event: if held_code matches, set held=0 and held_code=0. A non-matching break changes only the evt_* outputs.
- Prefix timeout: the counter runs while (ext_pend|brk_pend) and state==IDLE and fifo_ready==0, and resets whenever a byte is popped. When it reaches TIMEOUT_CYCLES-1, both prefixes clear and no event is emitted.
- Overflow: fifo_overflow==1 in any cycle sets ovf_err and clears the prefixes at the next DECODE boundary. Draining continues.
- clr_err==1 clears ovf_err. If fifo_overflow is also 1 in the same cycle, set wins.
- Latency: fifo_ready rising in IDLE -> evt_valid 4 cycles later for a plain make code. Two-byte and three-byte sequences take 4 cycles per byte.

Decomposition:
- Shared package kbd_pkg holds:
  - state enum: IDLE, POP, SETTLE, DECODE
  - constants: SC_EXT=8'hE0, SC_BRK=8'hF0, SC_ERR0=8'h00, SC_ERR1=8'hFF
  - typedef key_t = struct {ext, code[7:0]}
- One natural sub-module: kbd_prefix_timer, which holds the timeout counter with inputs start/clear and output expire.

Test Plan:
- FIFO bytes 1C -> one pop; evt_valid 4 cycles after fifo_ready; evt_code=1C, ext=0, brk=0; press_count=1; held_code=0x01C.
- Bytes 1C,1C,1C (typematic), then F0,1C -> three make events and one break; press_count=1; held=0 after the break; nextdata_n low exactly 5 single cycles.
- Bytes E0,75,E0,F0,75 -> make event code=75, ext=1, held_code=0x175; break event ext=1, brk=1; held=0; press_count=1.
- E0 followed by silence for TIMEOUT_CYCLES (test with parameter 16), then 1C -> event ext=0; press_count increments.
- Press 256 distinct-alternating codes (1C,32,1C,32,... with breaks between) -> press_count wraps to 0 after the 256th make.
- fifo_overflow pulse with E0 pending -> ovf_err=1, prefix dropped; clr_err and overflow in the same cycle -> ovf_err stays 1; rst low mid-POP -> all outputs zero and nextdata_n=1 next cycle.
